tx_queue_sched: RTL and testbench
=================================

Name: tx_queue_sched

Overview:
- Schedules transmission from the four per-queue 64-bit TX DMA FIFOs in the tx_intf high block.
- Selects which queue feeds the accelerator: drives tx_queue_idx, then sequences the FWFT reads through acc_ask_data for exactly one packet's worth of words.
- Grants only queues holding a complete packet; strict-priority or round-robin arbitration, per-queue enable gating.
- Sits between the four tx FIFOs (data_count, EMPTYN_TO_ACC) and the TX PHY front end (tx_busy).

Parameters:
- MAX_BIT_NUM_DMA_SYMBOL, 14, width of FIFO data counts and packet lengths in 64-bit words.
- TIMEOUT_CYCLES, 1024, starvation watchdog limit in READ; used only with TX_SCHED_TIMEOUT_EN.

Ports:
- S_AXIS_ACLK  in  1  single clock for the block.
- S_AXIS_ARESETN  in  1  asynchronous, active-low reset.
- data_count0..data_count3  in  MAX_BIT_NUM_DMA_SYMBOL each  word occupancy of queue 0..3.
- pkt_len0..pkt_len3  in  MAX_BIT_NUM_DMA_SYMBOL each  head-packet length in words for queue 0..3; 0 means none.
- queue_enable  in  4  per-queue transmit permission; bit i is queue i.
- sched_mode  in  1  0 = strict priority (queue 3 highest), 1 = round robin.
- tx_busy  in  1  downstream busy; no new grant while high.
- emptyn_to_acc  in  1  not-empty of the currently selected FIFO.
- tx_queue_idx  out  2  selected queue (FIFO read mux select).
- acc_ask_data  out  1  FWFT read enable to the selected FIFO.
- pkt_start  out  1  one-cycle pulse at grant.
- pkt_done  out  1  one-cycle pulse after the last word is read.
- pkt_abort  out  1  one-cycle pulse on watchdog abort.
- active_len  out  MAX_BIT_NUM_DMA_SYMBOL  length latched at grant.
- sched_busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (async, S_AXIS_ARESETN=0), all values 0:
  - state=IDLE, tx_queue_idx=0, rr_ptr=0, word_cnt=0, active_len=0.
  - pkt_start, pkt_done and pkt_abort low; sched_busy low.
- Reset mid-packet abandons the packet immediately; no pulse is emitted; FIFO contents are not touched.
- Eligibility, combinational: elig[i] = queue_enable[i] && pkt_len_i!=0 && data_count_i >= pkt_len_i (unsigned compare).
- States:
  - IDLE: if !tx_busy && |elig, go to GRANT. Otherwise stay.
  - GRANT, one cycle: register the winner into tx_queue_idx, latch active_len=pkt_len_winner, clear word_cnt, pulse pkt_start.
    - Round robin: rr_ptr <= winner+1 (mod 4).
    - If elig has cleared by this cycle, no grant is made: return to IDLE with no pulse.
    - Otherwise go to READ.
  - READ: acc_ask_data = (state==READ) && emptyn_to_acc && word_cnt < active_len, combinational.
    - Each acc_ask_data cycle increments word_cnt.
    - The cycle in which word_cnt reaches active_len goes to DONE.
  - DONE: pulse pkt_done, then go to IDLE. tx_queue_idx holds its value until the next grant.
- Latency: a packet that is eligible in IDLE gives pkt_start 1 cycle later and the first acc_ask_data 2 cycles later. With the FIFO never empty, words are read back to back, and pkt_done comes 1 cycle after the last read.
- Arbitration:
  - Strict priority: the highest-index eligible queue wins.
  - Round robin: the first eligible queue scanning from rr_ptr upward wins, wrapping 3 to 0.
- tx_busy, queue_enable and pkt_len changes after grant have no effect on the packet in flight.
- emptyn_to_acc low in READ stalls reads; word_cnt holds.
- acc_ask_data is never asserted outside READ and never beyond active_len words.

Optional Feature:
- TX_SCHED_TIMEOUT_EN defined:
  - A stall counter increments on each READ cycle with emptyn_to_acc low and clears on each read.
  - Reaching TIMEOUT_CYCLES pulses pkt_abort and returns to IDLE.
  - Remaining words of the packet stay in the FIFO.
- TX_SCHED_TIMEOUT_EN undefined: no counter; READ waits indefinitely; pkt_abort is tied to 0.

Decomposition:
- Package tx_sched_pkg holds:
  - state encodings IDLE/GRANT/READ/DONE;
  - NUM_QUEUE=4 and QIDX_W=2;
  - sched_mode encodings SCHED_PRIO=0 and SCHED_RR=1.
- Sub-module tx_sched_arb: combinational 4-way arbiter with inputs elig[3:0], rr_ptr and sched_mode, outputs winner[1:0] and any_elig.

Test Plan:
- Reset and single packet:
  - Stimulus: queue 1 enabled, pkt_len1=5, data_count1=5, FIFO non-empty, tx_busy=0.
  - Required: tx_queue_idx=1; exactly 5 acc_ask_data cycles; pkt_start, then pkt_done 1 cycle after the 5th read; sched_busy low afterwards.
- Strict priority:
  - Stimulus: queues 0 and 2 eligible, sched_mode=0.
  - Required: queue 2 is served first, then queue 0.
- Round robin:
  - Stimulus: all four queues continuously eligible, sched_mode=1.
  - Required: grant order 0,1,2,3,0.
- Incomplete packet and gating:
  - Case A: pkt_len0=8, data_count0=7 -> no grant.
  - Case B: data_count0 raised to 8 while tx_busy=1 -> no grant.
  - Case C: tx_busy then drops -> grant to queue 0.
- Stall and timeout:
  - Stimulus: emptyn_to_acc deasserted for 3 cycles mid-packet.
  - Required: word_cnt holds and reading resumes.
  - With TX_SCHED_TIMEOUT_EN and TIMEOUT_CYCLES=16, holding emptyn_to_acc low -> pkt_abort 16 cycles later, state returns to IDLE.
- Async reset mid-READ:
  - Stimulus: S_AXIS_ARESETN low after 2 of 6 words are read.
  - Required: outputs go to reset values immediately; no pkt_done is emitted.

Source files
------------

// File: rtl/tx_sched_pkg.sv
// Shared definitions for the TX queue scheduler: FSM states, queue count and
// scheduling-mode encodings.
package tx_sched_pkg;

    localparam int unsigned NUM_QUEUE = 4;
    localparam int unsigned QIDX_W    = 2;

    localparam logic SCHED_PRIO = 1'b0;
    localparam logic SCHED_RR   = 1'b1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        READ  = 2'd2,
        DONE  = 2'd3
    } tx_sched_state_t;

endpackage

// File: rtl/tx_sched_arb.sv
// Combinational 4-way arbiter: strict priority (highest index wins) or
// round robin scanning upward from rr_ptr with wrap from 3 to 0.
module tx_sched_arb
    import tx_sched_pkg::*;
(
    input  logic [NUM_QUEUE-1:0] elig,
    input  logic [QIDX_W-1:0]    rr_ptr,
    input  logic                 sched_mode,
    output logic [QIDX_W-1:0]    winner,
    output logic                 any_elig
);

    // Pick the first eligible queue in the order the current mode defines.
    always_comb begin
        logic              found;
        logic [QIDX_W-1:0] idx;
        winner = '0;
        found  = 1'b0;
        idx    = '0;
        if (sched_mode == SCHED_RR) begin
            for (int k = 0; k < NUM_QUEUE; k++) begin
                // 2-bit add wraps naturally past queue 3
                idx = rr_ptr + QIDX_W'(k);
                if (!found && elig[idx]) begin
                    winner = idx;
                    found  = 1'b1;
                end
            end
        end else begin
            for (int i = NUM_QUEUE - 1; i >= 0; i--) begin
                if (!found && elig[i]) begin
                    winner = QIDX_W'(i);
                    found  = 1'b1;
                end
            end
        end
    end

    assign any_elig = |elig;

endmodule

// File: rtl/tx_queue_sched.sv
// TX queue scheduler: grants one of four DMA FIFOs holding a complete packet
// and sequences FWFT reads for exactly that packet's length.
// Optional starvation watchdog in READ: define TX_SCHED_TIMEOUT_EN.
module tx_queue_sched
    import tx_sched_pkg::*;
#(
    parameter int unsigned MAX_BIT_NUM_DMA_SYMBOL = 14,
    parameter int unsigned TIMEOUT_CYCLES         = 1024
) (
    input  logic                              S_AXIS_ACLK,
    input  logic                              S_AXIS_ARESETN,
    input  logic [MAX_BIT_NUM_DMA_SYMBOL-1:0] data_count0,
    input  logic [MAX_BIT_NUM_DMA_SYMBOL-1:0] data_count1,
    input  logic [MAX_BIT_NUM_DMA_SYMBOL-1:0] data_count2,
    input  logic [MAX_BIT_NUM_DMA_SYMBOL-1:0] data_count3,
    input  logic [MAX_BIT_NUM_DMA_SYMBOL-1:0] pkt_len0,
    input  logic [MAX_BIT_NUM_DMA_SYMBOL-1:0] pkt_len1,
    input  logic [MAX_BIT_NUM_DMA_SYMBOL-1:0] pkt_len2,
    input  logic [MAX_BIT_NUM_DMA_SYMBOL-1:0] pkt_len3,
    input  logic [3:0]                        queue_enable,
    input  logic                              sched_mode,
    input  logic                              tx_busy,
    input  logic                              emptyn_to_acc,
    output logic [1:0]                        tx_queue_idx,
    output logic                              acc_ask_data,
    output logic                              pkt_start,
    output logic                              pkt_done,
    output logic                              pkt_abort,
    output logic [MAX_BIT_NUM_DMA_SYMBOL-1:0] active_len,
    output logic                              sched_busy
);

    localparam int unsigned W = MAX_BIT_NUM_DMA_SYMBOL;

    tx_sched_state_t   state_q;
    logic [QIDX_W-1:0] rr_ptr_q;
    logic [W-1:0]      word_cnt_q;

    logic [W-1:0]          dc_arr  [NUM_QUEUE];
    logic [W-1:0]          len_arr [NUM_QUEUE];
    logic [NUM_QUEUE-1:0]  elig;
    logic [QIDX_W-1:0]     winner;
    logic                  any_elig;

`ifdef TX_SCHED_TIMEOUT_EN
    localparam int unsigned STALL_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [STALL_W-1:0] stall_cnt_q;
    logic               abort_q;
`endif

    assign dc_arr[0]  = data_count0;
    assign dc_arr[1]  = data_count1;
    assign dc_arr[2]  = data_count2;
    assign dc_arr[3]  = data_count3;
    assign len_arr[0] = pkt_len0;
    assign len_arr[1] = pkt_len1;
    assign len_arr[2] = pkt_len2;
    assign len_arr[3] = pkt_len3;

    // A queue is eligible only when its whole head packet is already buffered.
    always_comb begin
        for (int i = 0; i < NUM_QUEUE; i++) begin
            elig[i] = queue_enable[i] && (len_arr[i] != '0) && (dc_arr[i] >= len_arr[i]);
        end
    end

    tx_sched_arb u_arb (
        .elig       (elig),
        .rr_ptr     (rr_ptr_q),
        .sched_mode (sched_mode),
        .winner     (winner),
        .any_elig   (any_elig)
    );

    // Read strobe and status decoded from the registered state.
    always_comb begin
        acc_ask_data = (state_q == READ) && emptyn_to_acc && (word_cnt_q < active_len);
        // Qualified by any_elig so a grant withdrawn in GRANT emits no pulse
        pkt_start    = (state_q == GRANT) && any_elig;
        sched_busy   = (state_q != IDLE);
    end

    // Scheduler FSM with its registered outputs.
    always_ff @(posedge S_AXIS_ACLK or negedge S_AXIS_ARESETN) begin
        if (!S_AXIS_ARESETN) begin
            state_q      <= IDLE;
            tx_queue_idx <= '0;
            rr_ptr_q     <= '0;
            word_cnt_q   <= '0;
            active_len   <= '0;
            pkt_done     <= 1'b0;
`ifdef TX_SCHED_TIMEOUT_EN
            stall_cnt_q  <= '0;
            abort_q      <= 1'b0;
`endif
        end else begin
            pkt_done <= 1'b0;
`ifdef TX_SCHED_TIMEOUT_EN
            abort_q  <= 1'b0;
`endif
            case (state_q)
                IDLE: begin
                    if (!tx_busy && any_elig) begin
                        state_q <= GRANT;
                    end
                end
                GRANT: begin
                    if (any_elig) begin
                        tx_queue_idx <= winner;
                        active_len   <= len_arr[winner];
                        word_cnt_q   <= '0;
`ifdef TX_SCHED_TIMEOUT_EN
                        stall_cnt_q  <= '0;
`endif
                        if (sched_mode == SCHED_RR) begin
                            rr_ptr_q <= winner + 1'b1;
                        end
                        state_q <= READ;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                READ: begin
                    if (acc_ask_data) begin
                        word_cnt_q <= word_cnt_q + 1'b1;
`ifdef TX_SCHED_TIMEOUT_EN
                        stall_cnt_q <= '0;
`endif
                        if (word_cnt_q + 1'b1 == active_len) begin
                            pkt_done <= 1'b1;
                            state_q  <= DONE;
                        end
                    end
`ifdef TX_SCHED_TIMEOUT_EN
                    else if (!emptyn_to_acc) begin
                        // Give up on a starved FIFO; unread words stay queued
                        if (stall_cnt_q == STALL_W'(TIMEOUT_CYCLES - 1)) begin
                            abort_q <= 1'b1;
                            state_q <= IDLE;
                        end else begin
                            stall_cnt_q <= stall_cnt_q + 1'b1;
                        end
                    end
`endif
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

`ifdef TX_SCHED_TIMEOUT_EN
    assign pkt_abort = abort_q;
`else
    assign pkt_abort = 1'b0;
`endif

endmodule

// File: tb/tb_tx_queue_sched.sv
// Scoreboard bench for tx_queue_sched: expected (queue, words) pairs are queued
// when packets are loaded and compared at each pkt_done.
module tb_tx_queue_sched;

    localparam int unsigned W   = 14;
    localparam int unsigned TMO = 16;

    logic         S_AXIS_ACLK = 1'b0;
    logic         S_AXIS_ARESETN;
    logic [W-1:0] data_count0, data_count1, data_count2, data_count3;
    logic [W-1:0] pkt_len0, pkt_len1, pkt_len2, pkt_len3;
    logic [3:0]   queue_enable;
    logic         sched_mode;
    logic         tx_busy;
    logic         emptyn_to_acc;
    logic [1:0]   tx_queue_idx;
    logic         acc_ask_data;
    logic         pkt_start;
    logic         pkt_done;
    logic         pkt_abort;
    logic [W-1:0] active_len;
    logic         sched_busy;

    typedef struct {
        int q;
        int len;
    } exp_t;

    exp_t sb[$];
    int   pend[4][$];
    int   dcm[4];
    int   n_checks  = 0;
    int   n_fail    = 0;
    int   rd_cnt    = 0;
    int   done_cnt  = 0;
    int   start_cnt = 0;
    int   abort_cnt = 0;

    tx_queue_sched #(
        .MAX_BIT_NUM_DMA_SYMBOL (W),
        .TIMEOUT_CYCLES         (TMO)
    ) dut (
        .S_AXIS_ACLK    (S_AXIS_ACLK),
        .S_AXIS_ARESETN (S_AXIS_ARESETN),
        .data_count0    (data_count0),
        .data_count1    (data_count1),
        .data_count2    (data_count2),
        .data_count3    (data_count3),
        .pkt_len0       (pkt_len0),
        .pkt_len1       (pkt_len1),
        .pkt_len2       (pkt_len2),
        .pkt_len3       (pkt_len3),
        .queue_enable   (queue_enable),
        .sched_mode     (sched_mode),
        .tx_busy        (tx_busy),
        .emptyn_to_acc  (emptyn_to_acc),
        .tx_queue_idx   (tx_queue_idx),
        .acc_ask_data   (acc_ask_data),
        .pkt_start      (pkt_start),
        .pkt_done       (pkt_done),
        .pkt_abort      (pkt_abort),
        .active_len     (active_len),
        .sched_busy     (sched_busy)
    );

    always #5 S_AXIS_ACLK = ~S_AXIS_ACLK;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] head_len(input int q);
        if (pend[q].size() == 0) return '0;
        return W'(pend[q][0]);
    endfunction

    // Present the FIFO model on the DUT inputs.
    task automatic drive_model();
        data_count0 = W'(dcm[0]);
        data_count1 = W'(dcm[1]);
        data_count2 = W'(dcm[2]);
        data_count3 = W'(dcm[3]);
        pkt_len0    = head_len(0);
        pkt_len1    = head_len(1);
        pkt_len2    = head_len(2);
        pkt_len3    = head_len(3);
    endtask

    task automatic load(input int q, input int len, input bit expect_done);
        exp_t e;
        pend[q].push_back(len);
        dcm[q] += len;
        if (expect_done) begin
            e.q   = q;
            e.len = len;
            sb.push_back(e);
        end
        drive_model();
    endtask

    task automatic clear_model();
        for (int i = 0; i < 4; i++) begin
            pend[i].delete();
            dcm[i] = 0;
        end
        drive_model();
    endtask

    task automatic drive_step();
        @(posedge S_AXIS_ACLK);
        #1;
    endtask

    task automatic sample_step();
        @(negedge S_AXIS_ACLK);
        #1;
    endtask

    task automatic wait_done(input int target, input int budget);
        int n = 0;
        while (done_cnt < target && n < budget) begin
            sample_step();
            n++;
        end
        check_val("wait_done", done_cnt, target);
    endtask

    task automatic wait_rd(input int target, input int budget);
        int n = 0;
        while (rd_cnt < target && n < budget) begin
            drive_step();
            n++;
        end
        check_val("wait_reads", rd_cnt, target);
    endtask

    // FIFO model and scoreboard monitor, sampled on the falling edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge S_AXIS_ACLK);
            if (!S_AXIS_ARESETN) begin
                rd_cnt = 0;
            end else begin
                if (pkt_start) begin
                    start_cnt++;
                    rd_cnt = 0;
                end
                if (acc_ask_data) begin
                    check_val("ask_needs_emptyn", emptyn_to_acc, 1);
                    rd_cnt++;
                    check_val("ask_within_len", (rd_cnt <= int'(active_len)), 1);
                    if (dcm[tx_queue_idx] > 0) dcm[tx_queue_idx]--;
                end
                if (pkt_done) begin
                    done_cnt++;
                    if (sb.size() == 0) begin
                        check_val("unexpected_done", sb.size(), 1);
                    end else begin
                        e = sb.pop_front();
                        check_val("done_queue", tx_queue_idx, e.q);
                        check_val("done_words", rd_cnt, e.len);
                    end
                    if (pend[tx_queue_idx].size() > 0) void'(pend[tx_queue_idx].pop_front());
                    rd_cnt = 0;
                end
                if (pkt_abort) begin
                    abort_cnt++;
                    rd_cnt = 0;
                end
                drive_model();
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

    initial begin
        int base;
        int n;

        S_AXIS_ARESETN = 1'b0;
        queue_enable   = 4'b0000;
        sched_mode     = 1'b0;
        tx_busy        = 1'b0;
        emptyn_to_acc  = 1'b1;
        clear_model();
        repeat (3) sample_step();

        check_val("rst_idx", tx_queue_idx, 0);
        check_val("rst_ask", acc_ask_data, 0);
        check_val("rst_start", pkt_start, 0);
        check_val("rst_done", pkt_done, 0);
        check_val("rst_abort", pkt_abort, 0);
        check_val("rst_len", active_len, 0);
        check_val("rst_busy", sched_busy, 0);

        drive_step();
        S_AXIS_ARESETN = 1'b1;
        repeat (2) drive_step();

        // Single packet on queue 1 with latency checks.
        queue_enable = 4'b0010;
        load(1, 5, 1'b1);
        base = done_cnt;
        sample_step();
        check_val("single_idle_start", pkt_start, 0);
        sample_step();
        check_val("single_grant_start", pkt_start, 1);
        check_val("single_grant_ask", acc_ask_data, 0);
        sample_step();
        check_val("single_first_ask", acc_ask_data, 1);
        check_val("single_idx", tx_queue_idx, 1);
        check_val("single_len", active_len, 5);
        wait_done(base + 1, 20);
        check_val("single_done_pulse", pkt_done, 1);
        check_val("single_done_noask", acc_ask_data, 0);
        sample_step();
        check_val("single_done_width", pkt_done, 0);
        check_val("single_busy_after", sched_busy, 0);

        // Strict priority: queue 2 before queue 0.
        drive_step();
        queue_enable = 4'b0101;
        load(2, 4, 1'b1);
        load(0, 3, 1'b1);
        wait_done(base + 3, 40);

        // Round robin across four continuously eligible queues.
        drive_step();
        sched_mode   = 1'b1;
        queue_enable = 4'b1111;
        for (int r = 0; r < 2; r++) begin
            for (int q = 0; q < 4; q++) load(q, 2, 1'b1);
        end
        wait_done(base + 11, 120);

        // Incomplete packet, then tx_busy gating, then grant.
        drive_step();
        sched_mode   = 1'b0;
        queue_enable = 4'b0001;
        n = start_cnt;
        pend[0].push_back(8);
        dcm[0] = 7;
        drive_model();
        repeat (10) sample_step();
        check_val("incomplete_no_start", start_cnt, n);
        check_val("incomplete_idle", sched_busy, 0);
        drive_step();
        tx_busy = 1'b1;
        dcm[0]  = 8;
        drive_model();
        repeat (10) sample_step();
        check_val("busy_no_start", start_cnt, n);
        check_val("busy_idle", sched_busy, 0);
        drive_step();
        begin
            exp_t e;
            e.q   = 0;
            e.len = 8;
            sb.push_back(e);
        end
        tx_busy = 1'b0;
        wait_rd(1, 10);
        // Changes after grant must not disturb the packet in flight.
        tx_busy      = 1'b1;
        queue_enable = 4'b0000;
        wait_done(base + 12, 30);
        drive_step();
        tx_busy = 1'b0;

        // Stall mid-packet for three cycles.
        queue_enable = 4'b1000;
        load(3, 6, 1'b1);
        wait_rd(2, 20);
        emptyn_to_acc = 1'b0;
        for (int i = 0; i < 3; i++) begin
            sample_step();
            check_val("stall_no_ask", acc_ask_data, 0);
            check_val("stall_hold_cnt", rd_cnt, 2);
            check_val("stall_busy", sched_busy, 1);
        end
        drive_step();
        emptyn_to_acc = 1'b1;
        wait_done(base + 13, 30);

        // Long stall: watchdog abort when enabled, indefinite wait otherwise.
        drive_step();
        queue_enable = 4'b0100;
`ifdef TX_SCHED_TIMEOUT_EN
        load(2, 4, 1'b0);
        wait_rd(1, 20);
        emptyn_to_acc = 1'b0;
        n = 0;
        while (!pkt_abort && n < 40) begin
            sample_step();
            if (!pkt_abort) n++;
        end
        check_val("abort_latency", n, TMO);
        check_val("abort_pulse", pkt_abort, 1);
        check_val("abort_idle", sched_busy, 0);
        check_val("abort_no_done", done_cnt, base + 13);
        drive_step();
        emptyn_to_acc = 1'b1;
        clear_model();
        sample_step();
        check_val("abort_width", pkt_abort, 0);
        check_val("abort_count", abort_cnt, 1);
`else
        load(2, 4, 1'b1);
        wait_rd(1, 20);
        emptyn_to_acc = 1'b0;
        for (int i = 0; i < 20; i++) begin
            sample_step();
            check_val("longstall_no_abort", pkt_abort, 0);
            check_val("longstall_busy", sched_busy, 1);
        end
        drive_step();
        emptyn_to_acc = 1'b1;
        wait_done(base + 14, 30);
        check_val("abort_count", abort_cnt, 0);
`endif

        // Async reset after 2 of 6 words: no pkt_done, outputs reset at once.
        drive_step();
        n = done_cnt;
        queue_enable = 4'b0010;
        load(1, 6, 1'b0);
        wait_rd(2, 20);
        S_AXIS_ARESETN = 1'b0;
        #1;
        check_val("arst_busy", sched_busy, 0);
        check_val("arst_ask", acc_ask_data, 0);
        check_val("arst_idx", tx_queue_idx, 0);
        check_val("arst_len", active_len, 0);
        check_val("arst_done", pkt_done, 0);
        clear_model();
        repeat (2) drive_step();
        S_AXIS_ARESETN = 1'b1;
        repeat (10) sample_step();
        check_val("arst_no_done", done_cnt, n);
        check_val("arst_idle", sched_busy, 0);
        check_val("sb_drained", sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
